// File: rtl/mpmc11_cmd_fifo_arb.sv
// ----------------------------------------------------------------------------
// mpmc11_cmd_fifo_arb
//
// Round-robin arbiter that pops one command at a time from up to eight
// requester command FIFOs and hands it to the memory controller. After a pop
// it waits for the controller to leave IDLE (acceptance). If the controller
// never leaves IDLE within TMO cycles, the arbiter raises a one-cycle timeout
// pulse and abandons the command. If the controller does accept, the arbiter
// waits for it to return to IDLE before looking for the next command.
//
// Ports
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   state          in   current controller state (mpmc11_state_t)
//   calib_complete in   memory calibration done; gates new grants only
//   empty          in   [NPORT] per-port command FIFO empty flags
//   rd_rst_busy    in   [NPORT] per-port FIFO read-side reset-busy flags
//   rd             out  [NPORT] one-hot FIFO pop strobe (registered)
//   sel            out  [3] index of the granted port (registered, sticky)
//   sel_valid      out  high while sel names the command being serviced
//   tmo_err        out  one-cycle pulse on acceptance timeout
// ----------------------------------------------------------------------------

package mpmc11_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACTIVATE = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        REFRESH  = 3'd4
    } mpmc11_state_t;

endpackage

module mpmc11_cmd_fifo_arb
    import mpmc11_pkg::*;
#(
    parameter int unsigned NPORT = 8,   // number of requester FIFOs, 2..8
    parameter int unsigned TMO   = 15   // acceptance timeout in cycles, 1..255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  mpmc11_state_t        state,
    input  logic                 calib_complete,
    input  logic [NPORT-1:0]     empty,
    input  logic [NPORT-1:0]     rd_rst_busy,
    output logic [NPORT-1:0]     rd,
    output logic [2:0]           sel,
    output logic                 sel_valid,
    output logic                 tmo_err
);

    localparam logic [1:0] A_IDLE = 2'd0;   // looking for a command
    localparam logic [1:0] A_WAIT = 2'd1;   // popped, waiting for controller to accept
    localparam logic [1:0] A_BUSY = 2'd2;   // accepted, waiting for controller to finish

    logic [1:0]       fsm_q, fsm_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [NPORT-1:0] rd_d;
    logic [2:0]       sel_d;
    logic             sel_valid_d;
    logic             tmo_err_d;

    logic [NPORT-1:0] eligible;
    logic [7:0]       elig8;
    logic             found;
    logic [2:0]       grant_idx;
    logic [3:0]       scan_sum;
    logic             grant_ok;
    logic [3:0]       ptr_inc;
    logic [7:0]       rd8;

    assign eligible = ~empty & ~rd_rst_busy;
    // Zero-extend so a 3-bit index is always in range whatever NPORT is.
    assign elig8    = 8'(eligible);

    // First eligible port scanning upward from ptr, wrapping modulo NPORT.
    always_comb begin
        found     = 1'b0;
        grant_idx = 3'd0;
        scan_sum  = 4'd0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            scan_sum = {1'b0, ptr_q} + 4'(k);
            if (scan_sum >= 4'(NPORT)) begin
                scan_sum = scan_sum - 4'(NPORT);
            end
            if (!found && elig8[scan_sum[2:0]]) begin
                found     = 1'b1;
                grant_idx = scan_sum[2:0];
            end
        end
    end

    // Grants are only considered from A_IDLE, so the edge that returns the
    // FSM to A_IDLE can never also pop a FIFO.
    assign grant_ok = (fsm_q == A_IDLE) && (state == IDLE) && calib_complete && found;

    assign ptr_inc = {1'b0, grant_idx} + 4'd1;
    assign rd8     = 8'd1 << grant_idx;

    always_comb begin
        fsm_d       = fsm_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rd_d        = '0;
        sel_d       = sel;
        sel_valid_d = sel_valid;
        tmo_err_d   = 1'b0;

        case (fsm_q)
            A_IDLE: begin
                if (grant_ok) begin
                    rd_d        = rd8[NPORT-1:0];
                    sel_d       = grant_idx;
                    sel_valid_d = 1'b1;
                    ptr_d       = (ptr_inc == 4'(NPORT)) ? 3'd0 : ptr_inc[2:0];
                    cnt_d       = 8'd0;
                    fsm_d       = A_WAIT;
                end
            end

            A_WAIT: begin
                if (state != IDLE) begin
                    fsm_d = A_BUSY;
                    cnt_d = 8'd0;
                end else if (cnt_q == 8'(TMO - 1)) begin
                    // This edge brings the count to TMO: give up on the command.
                    fsm_d       = A_IDLE;
                    tmo_err_d   = 1'b1;
                    sel_valid_d = 1'b0;
                    cnt_d       = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            A_BUSY: begin
                if (state == IDLE) begin
                    fsm_d       = A_IDLE;
                    sel_valid_d = 1'b0;
                end
            end

            default: begin
                fsm_d       = A_IDLE;
                sel_valid_d = 1'b0;
                cnt_d       = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= A_IDLE;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
            rd        <= '0;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rd        <= rd_d;
            sel       <= sel_d;
            sel_valid <= sel_valid_d;
            tmo_err   <= tmo_err_d;
        end
    end

    rd_onehot_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rd));

endmodule

// File: tb/tb_mpmc11_cmd_fifo_arb.sv
// ----------------------------------------------------------------------------
// tb_mpmc11_cmd_fifo_arb
//
// Bench for mpmc11_cmd_fifo_arb (NPORT=8, TMO=15): a hand-derived vector
// table, directed sequences for round-robin, timeout and reset, then random
// traffic checked against a transaction-level reference model.
// ----------------------------------------------------------------------------

module tb_mpmc11_cmd_fifo_arb;
    import mpmc11_pkg::*;

    localparam int NPORT = 8;
    localparam int TMO   = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    mpmc11_state_t state;
    logic          calib_complete;
    logic [7:0]    empty;
    logic [7:0]    rd_rst_busy;
    logic [7:0]    rd;
    logic [2:0]    sel;
    logic          sel_valid;
    logic          tmo_err;

    always #5 clk = ~clk;

    mpmc11_cmd_fifo_arb #(
        .NPORT(NPORT),
        .TMO  (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .calib_complete(calib_complete),
        .empty         (empty),
        .rd_rst_busy   (rd_rst_busy),
        .rd            (rd),
        .sel           (sel),
        .sel_valid     (sel_valid),
        .tmo_err       (tmo_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit         m_open;      // a popped command is outstanding
    bit         m_accepted;  // controller has left IDLE for it
    int         m_waited;    // IDLE cycles spent waiting for acceptance
    int         m_ptr;       // next port to start the search from
    int         m_sel;
    bit         m_sv;
    bit         m_tmo;
    logic [7:0] m_rd;

    function automatic void model_reset();
        m_open = 0; m_accepted = 0; m_waited = 0; m_ptr = 0;
        m_sel = 0; m_sv = 0; m_tmo = 0; m_rd = 8'h00;
    endfunction

    // Predicts the outputs after the coming clock edge from the current inputs.
    function automatic void model_step();
        int         g;
        logic [7:0] elig;
        logic [2:0] p3;
        m_rd  = 8'h00;
        m_tmo = 0;
        elig  = ~empty & ~rd_rst_busy;
        if (!m_open) begin
            g = -1;
            if (state == IDLE && calib_complete) begin
                for (int k = 0; k < NPORT; k++) begin
                    p3 = 3'((m_ptr + k) % NPORT);
                    if (g < 0 && elig[p3]) g = int'(p3);
                end
            end
            if (g >= 0) begin
                m_rd       = 8'd1 << g;
                m_sel      = g;
                m_sv       = 1;
                m_ptr      = (g + 1) % NPORT;
                m_open     = 1;
                m_accepted = 0;
                m_waited   = 0;
            end
        end else if (!m_accepted) begin
            if (state != IDLE) begin
                m_accepted = 1;
            end else begin
                m_waited++;
                if (m_waited >= TMO) begin
                    m_open = 0;
                    m_sv   = 0;
                    m_tmo  = 1;
                end
            end
        end else if (state == IDLE) begin
            m_open = 0;
            m_sv   = 0;
        end
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".rd"},        32'(rd),        32'(m_rd));
        check({tag, ".sel"},       32'(sel),       32'(m_sel));
        check({tag, ".sel_valid"}, 32'(sel_valid), 32'(m_sv));
        check({tag, ".tmo_err"},   32'(tmo_err),   32'(m_tmo));
    endtask

    // Inputs are set one time unit after an edge; outputs sampled likewise.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model("reset_async");
        @(posedge clk);
        #1;
        compare_model("reset_held");
        rst_n = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]    empty;
        logic [7:0]    busy;
        logic          calib;
        mpmc11_state_t st;
        logic [7:0]    rd;
        logic [2:0]    sel;
        logic          sv;
        logic          tmo;
    } vec_t;

    vec_t vecs[$];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int grants[$];
        int exp_order[5];
        int n;
        int g;

        rst_n          = 1'b1;
        state          = IDLE;
        calib_complete = 1'b1;
        empty          = 8'hFF;
        rd_rst_busy    = 8'h00;
        #1;
        do_reset();

        // ---- table (rows are consecutive cycles from reset, ptr=0) ----
        vecs.push_back('{8'hFF, 8'h00, 1'b1, IDLE,     8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'hF7, 8'h00, 1'b1, IDLE,     8'h08, 3'd3, 1'b1, 1'b0}); // grant 3
        vecs.push_back('{8'hF7, 8'h00, 1'b1, IDLE,     8'h00, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{8'hF7, 8'h00, 1'b1, ACTIVATE, 8'h00, 3'd3, 1'b1, 1'b0}); // accepted
        vecs.push_back('{8'hFF, 8'h00, 1'b1, ACTIVATE, 8'h00, 3'd3, 1'b1, 1'b0}); // elig drop
        vecs.push_back('{8'hF7, 8'h00, 1'b1, IDLE,     8'h00, 3'd3, 1'b0, 1'b0}); // no regrant
        vecs.push_back('{8'hFB, 8'h04, 1'b1, IDLE,     8'h00, 3'd3, 1'b0, 1'b0}); // rst busy
        vecs.push_back('{8'hFB, 8'h04, 1'b1, IDLE,     8'h00, 3'd3, 1'b0, 1'b0});
        vecs.push_back('{8'hFB, 8'h00, 1'b1, IDLE,     8'h04, 3'd2, 1'b1, 1'b0}); // grant 2
        vecs.push_back('{8'hFB, 8'h00, 1'b1, ACTIVATE, 8'h00, 3'd2, 1'b1, 1'b0});
        vecs.push_back('{8'hFB, 8'h00, 1'b0, ACTIVATE, 8'h00, 3'd2, 1'b1, 1'b0}); // calib fall
        vecs.push_back('{8'hFB, 8'h00, 1'b0, IDLE,     8'h00, 3'd2, 1'b0, 1'b0});
        vecs.push_back('{8'hFB, 8'h00, 1'b0, IDLE,     8'h00, 3'd2, 1'b0, 1'b0}); // calib gate
        vecs.push_back('{8'hFB, 8'h00, 1'b1, IDLE,     8'h04, 3'd2, 1'b1, 1'b0}); // grant 2
        vecs.push_back('{8'hFF, 8'h00, 1'b1, ACTIVATE, 8'h00, 3'd2, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 1'b1, IDLE,     8'h00, 3'd2, 1'b0, 1'b0});
        vecs.push_back('{8'hBF, 8'h00, 1'b1, IDLE,     8'h40, 3'd6, 1'b1, 1'b0}); // ptr -> 7
        vecs.push_back('{8'hFF, 8'h00, 1'b1, ACTIVATE, 8'h00, 3'd6, 1'b1, 1'b0});
        vecs.push_back('{8'hFE, 8'h00, 1'b1, IDLE,     8'h00, 3'd6, 1'b0, 1'b0});
        vecs.push_back('{8'hFE, 8'h00, 1'b1, IDLE,     8'h01, 3'd0, 1'b1, 1'b0}); // wrap to 0
        vecs.push_back('{8'h7E, 8'h00, 1'b1, ACTIVATE, 8'h00, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{8'h7E, 8'h00, 1'b1, IDLE,     8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{8'h7E, 8'h00, 1'b1, IDLE,     8'h80, 3'd7, 1'b1, 1'b0}); // ptr was 1
        vecs.push_back('{8'h7E, 8'h00, 1'b1, ACTIVATE, 8'h00, 3'd7, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 1'b1, IDLE,     8'h00, 3'd7, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            empty          = vecs[i].empty;
            rd_rst_busy    = vecs[i].busy;
            calib_complete = vecs[i].calib;
            state          = vecs[i].st;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.rd", i),        32'(rd),        32'(vecs[i].rd));
            check($sformatf("vec%0d.sel", i),       32'(sel),       32'(vecs[i].sel));
            check($sformatf("vec%0d.sel_valid", i), 32'(sel_valid), 32'(vecs[i].sv));
            check($sformatf("vec%0d.tmo_err", i),   32'(tmo_err),   32'(vecs[i].tmo));
        end

        // ---- round-robin: ports 1, 5, 6 always eligible ----
        state = IDLE; calib_complete = 1'b1; rd_rst_busy = 8'h00; empty = 8'hFF;
        do_reset();
        empty = 8'h9D;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 4; c++) begin
                state = (c == 1 || c == 2) ? ACTIVATE : IDLE;
                tick("rr");
                g = onehot_idx(rd);
                if (g >= 0) grants.push_back(g);
            end
        end
        exp_order = '{1, 5, 6, 1, 5};
        check("rr.count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            check($sformatf("rr.order%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        end

        // ---- timeout: ports 2 and 4 eligible, controller stays IDLE ----
        state = IDLE; empty = 8'hFF;
        do_reset();
        empty = 8'hEB;
        tick("tmo.grant");
        check("tmo.first_grant", 32'(rd), 32'h04);
        n = 0;
        do begin
            tick("tmo.wait");
            n++;
        end while (!tmo_err && n < 40);
        check("tmo.latency", 32'(n), 32'(TMO));
        check("tmo.sel_valid", 32'(sel_valid), 32'd0);
        tick("tmo.next");
        check("tmo.next_grant", 32'(rd), 32'h10);
        check("tmo.pulse_end", 32'(tmo_err), 32'd0);

        // ---- reset mid-transaction with sel=5 ----
        state = IDLE; empty = 8'hFF;
        do_reset();
        empty = 8'hDF;
        tick("rst.grant");
        state = ACTIVATE;
        tick("rst.busy");
        tick("rst.busy2");
        check("rst.pre_sel", 32'(sel), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.async_sel", 32'(sel), 32'd0);
        check("rst.async_sv", 32'(sel_valid), 32'd0);
        check("rst.async_rd", 32'(rd), 32'd0);
        @(posedge clk);
        #1;
        compare_model("rst.held");
        rst_n = 1'b1;
        state = IDLE;
        tick("rst.regrant");
        check("rst.regrant_rd", 32'(rd), 32'h20);
        state = ACTIVATE;
        tick("rst.acc");
        state = IDLE;
        tick("rst.done");
        empty = 8'h6F;  // ports 4 and 7: ptr=6 must pick 7
        tick("rst.ptr6");
        check("rst.ptr6_rd", 32'(rd), 32'h80);

        // ---- random traffic against the model ----
        state = IDLE; empty = 8'hFF; rd_rst_busy = 8'h00;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 7) == 0) begin
                state = ($urandom_range(0, 1) == 0) ? IDLE
                                                    : mpmc11_state_t'($urandom_range(1, 4));
            end
            empty          = 8'($urandom);
            rd_rst_busy    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            calib_complete = ($urandom_range(0, 9) != 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpmc11_cmd_fifo_arb.md
MPMC11_CMD_FIFO_ARB -- requirements
Module: mpmc11_cmd_fifo_arb

Interface
REQ-001 The block SHALL take parameter NPORT, default 8, as the number of requester command FIFOs (legal values 2..8).
REQ-002 The block SHALL take parameter TMO, default 15, as the acceptance-timeout limit in cycles (legal values 1..255).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset; reset is asynchronous and active-low.
REQ-005 The block SHALL have port state, input, mpmc11_state_t, the current controller state.
REQ-006 The block SHALL have port calib_complete, input, 1, high once memory calibration is done.
REQ-007 The block SHALL have port empty, input, NPORT, the per-port command FIFO empty flags.
REQ-008 The block SHALL have port rd_rst_busy, input, NPORT, the per-port FIFO read-side reset-busy flags.
REQ-009 The block SHALL have port rd, output, NPORT, the one-hot per-port FIFO pop strobe, registered.
REQ-010 The block SHALL have port sel, output, 3, the index of the granted port, registered.
REQ-011 The block SHALL have port sel_valid, output, 1, high while sel identifies the command being serviced.
REQ-012 The block SHALL have port tmo_err, output, 1, a one-cycle pulse on acceptance timeout.

Function
REQ-013 Port i SHALL be eligible when empty[i]=0 and rd_rst_busy[i]=0.
REQ-014 A grant SHALL be possible only when the FSM is in A_IDLE, state==IDLE, calib_complete=1 and at least one port is eligible.
REQ-015 The granted port SHALL be the first eligible port found scanning upward from ptr and wrapping modulo NPORT.
REQ-016 On a grant to port g, in the next cycle: rd[g]=1 for exactly one cycle, sel=g, sel_valid=1, FSM goes to A_WAIT, and ptr becomes (g+1) mod NPORT.
REQ-017 rd SHALL never have more than one bit set, and SHALL be all-zero in every cycle except grant cycles.
REQ-018 FSM states SHALL be A_IDLE, A_WAIT and A_BUSY.
REQ-019 In A_WAIT, when state!=IDLE the FSM SHALL go to A_BUSY and clear the timeout counter.
REQ-020 In A_WAIT, when state==IDLE the timeout counter SHALL increment; when it reaches TMO the FSM SHALL go to A_IDLE, pulse tmo_err for one cycle, clear sel_valid and clear the counter.
REQ-021 In A_BUSY, when state==IDLE the FSM SHALL go to A_IDLE and clear sel_valid in the same edge.
REQ-022 A new grant SHALL NOT be issued in the same cycle the FSM returns to A_IDLE; the earliest new rd is 2 cycles after state returns to IDLE.
REQ-023 sel SHALL hold its value from the grant until the next grant, including while sel_valid=0.
REQ-024 ptr SHALL advance only on a grant; after a timeout, ptr SHALL keep its post-grant value.
REQ-025 If calib_complete falls while in A_WAIT or A_BUSY, the transaction SHALL complete normally; only new grants are blocked.
REQ-026 If eligibility of the granted port changes after the grant, sel and sel_valid SHALL be unaffected.

Reset
REQ-027 While rst_n=0, and from its falling edge without waiting for clk, the block SHALL force rd=0, sel=0, sel_valid=0, tmo_err=0, ptr=0, counter=0 and FSM=A_IDLE.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no rd pulse; the first grant after reset release SHALL follow REQ-014/015 with ptr=0.

Verification
REQ-029 Scenario 1: NPORT=8, calib_complete=1, state=IDLE, empty=8'hFF except empty[3]=0 -> next cycle rd=8'h08, sel=3, sel_valid=1, ptr=4.
REQ-030 Scenario 2 (round-robin): ports 1, 5 and 6 are continuously eligible, and the controller cycles IDLE -> non-IDLE -> IDLE after each grant -> grants occur in order 1, 5, 6, 1, 5.
REQ-031 Scenario 3 (timeout): after a grant, state stays IDLE for 15 cycles -> tmo_err=1 for one cycle, sel_valid=0, and the next grant goes to the next eligible port after the timed-out one.
REQ-032 Scenario 4 (gating): port 2 not empty but rd_rst_busy[2]=1, or calib_complete=0 -> rd stays 0; deassert the blocker -> rd=8'h04 one cycle later.
REQ-033 Scenario 5 (reset): rst_n pulled low while in A_BUSY with sel=5 -> sel=0 and sel_valid=0 immediately; after release with port 5 eligible -> grant to port 5 with ptr=6.
REQ-034 Scenario 6 (wrap): ptr=7 with only port 0 eligible -> rd=8'h01 and ptr=1.
